mult32_seq: RTL and testbench

Multi-cycle 32×32→64 multiplier for the CPU's MULT/MULTU path, sitting directly downstream of the ALU operand muxes. It drives the existing 32-bit carry-lookahead adder `full_adder32` with a shift-add sequence and delivers the product as HI/LO words. Signed operands are handled by sign-magnitude conversion, and every negation goes through the same adder instance. A start/busy/done handshake lets the control unit stall the pipeline while a multiply is in flight.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/full_adder32.sv | 38 +++
 rtl/mult32_seq.sv | 159 +++++++++++++++
 tb/tb_mult32_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the multiplier FSM encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    CALC   = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } mult_state_t;

endpackage

// File: rtl/full_adder32.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups with rippled group carries.
module full_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each group resolves its four internal carries directly from its carry-in.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int blk = 0; blk < 8; blk++) begin
      c[4*blk+1] = g[4*blk] | (p[4*blk] & c[4*blk]);
      c[4*blk+2] = g[4*blk+1] | (p[4*blk+1] & g[4*blk])
                 | (p[4*blk+1] & p[4*blk] & c[4*blk]);
      c[4*blk+3] = g[4*blk+2] | (p[4*blk+2] & g[4*blk+1])
                 | (p[4*blk+2] & p[4*blk+1] & g[4*blk])
                 | (p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
      c[4*blk+4] = g[4*blk+3] | (p[4*blk+3] & g[4*blk+2])
                 | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
                 | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk])
                 | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/mult32_seq.sv
// Sequential shift-add 32x32->64 multiplier for MULT/MULTU; all arithmetic,
// including sign-magnitude negations, goes through one shared full_adder32.
module mult32_seq #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  import cpu_pkg::*;

  mult_state_t state;
  mult_state_t state_nxt;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic              sgn;
  logic              fix_c;

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  logic [DATA_W-1:0] calc_acc;
  logic [DATA_W-1:0] calc_mplr;

  full_adder32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Negations are ~x + 0 + cin; FIX_HI reuses the low-word carry to finish the 64-bit negate.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      NEG_A: begin
        add_a   = ~mcand;
        add_cin = 1'b1;
      end
      NEG_B: begin
        add_a   = ~mplr;
        add_cin = 1'b1;
      end
      CALC: begin
        add_a = acc;
        add_b = mplr[0] ? mcand : '0;
      end
      FIX_LO: begin
        add_a   = ~mplr;
        add_cin = 1'b1;
      end
      FIX_HI: begin
        add_a   = ~acc;
        add_cin = fix_c;
      end
      default: begin
      end
    endcase
  end

  assign calc_acc  = {add_cout, add_sum[DATA_W-1:1]};
  assign calc_mplr = {add_sum[0], mplr[DATA_W-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_signed && dina[DATA_W-1])      state_nxt = NEG_A;
          else if (is_signed && dinb[DATA_W-1]) state_nxt = NEG_B;
          else                                  state_nxt = CALC;
        end
      end
      NEG_A:   state_nxt = (sgn && mplr[DATA_W-1]) ? NEG_B : CALC;
      NEG_B:   state_nxt = CALC;
      CALC: begin
        if (cnt == '1) state_nxt = neg ? FIX_LO : DONE;
      end
      FIX_LO:  state_nxt = FIX_HI;
      FIX_HI:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
      fix_c <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= dina;
            mplr  <= dinb;
            acc   <= '0;
            cnt   <= '0;
            neg   <= is_signed & (dina[DATA_W-1] ^ dinb[DATA_W-1]);
            sgn   <= is_signed;
          end
        end
        NEG_A: mcand <= add_sum;
        NEG_B: mplr  <= add_sum;
        CALC: begin
          acc  <= calc_acc;
          mplr <= calc_mplr;
          cnt  <= cnt + 1'b1;
        end
        FIX_LO: begin
          mplr  <= add_sum;
          fix_c <= add_cout;
        end
        FIX_HI: acc <= add_sum;
        default: begin
        end
      endcase

      // The product is published on the same edge that enters DONE.
      if (state == CALC && state_nxt == DONE) begin
        hi <= calc_acc;
        lo <= calc_mplr;
      end else if (state == FIX_HI) begin
        hi <= add_sum;
        lo <= mplr;
      end
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected products and latencies,
// a negedge monitor pops and compares on every done pulse.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dina;
  logic [31:0] dinb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mult32_seq #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dina      (dina),
    .dinb      (dinb),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accepts  = 0;
  int dones    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] refMul(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    if (s) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
      return xa * xb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int expLat(input bit s, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    if (s && a[31]) k++;
    if (s && b[31]) k++;
    if (s && (a[31] ^ b[31])) k += 2;
    return 32 + k;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1 with hi=0x%0h lo=0x%0h, required no pending request", hi, lo);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput({mon_e.name, "_hi"}, hi, mon_e.hi);
        checkOutput({mon_e.name, "_lo"}, lo, mon_e.lo);
        checkOutput({mon_e.name, "_latency"}, cyc - mon_e.acc_cyc, mon_e.lat);
      end
    end
  end

  // Waits for IDLE, presents the request, confirms acceptance and queues the expectation.
  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el, input int lat,
                               input string name, input bit hold);
    int n;
    is_signed = s;
    dina      = a;
    dinb      = b;
    start     = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_idle_wait: got busy=%b after 200 cycles, required 0", name, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_accept"}, busy, 1);
    sbq.push_back('{hi: eh, lo: el, lat: lat, acc_cyc: cyc, name: name});
    accepts++;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    logic [63:0] rp;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dina      = '0;
    dinb      = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, "multu_max", 1'b0);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    checkOutput("multu_max_busy_cycles", n, 33);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 35, "mult_neg7x6", 1'b0);

    applyStimulus(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0, 32'h0, 35, "mult_neg5x0", 1'b0);
    repeat (5) @(negedge clk);
    dina      = 32'd123;
    dinb      = 32'd456;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;

    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34, "mult_min_sq", 1'b0);

    // Abort a multiply mid-CALC; its expectation is withdrawn.
    rp = refMul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, rp[63:32], rp[31:0], 32, "aborted", 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    accepts--;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midcalc_reset_busy", busy, 0);
    checkOutput("midcalc_reset_done", done, 0);
    checkOutput("midcalc_reset_hi", hi, 0);
    checkOutput("midcalc_reset_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 32, "multu_3x4", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rp = refMul(rs, ra, rb);
      applyStimulus(rs, ra, rb, rp[63:32], rp[31:0], expLat(rs, ra, rb), "rand", 1'b1);
    end
    start = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    @(negedge clk);
    checkOutput("scoreboard_empty", sbq.size(), 0);
    checkOutput("done_count", dones, accepts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
